// File: rtl/equiv_sweep_checker_pkg.sv
// equiv_pkg: shared state encoding and width helpers for the sweep checker
package equiv_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
    function automatic int idx_w(input int n);
        return (n > 1) ? clog2(n) : 1;
    endfunction
endpackage

// File: rtl/equiv_sweep_checker_if.sv
// equiv_sweep_checker_if: stimulus and result bus between the checker and the two DUTs
interface equiv_sweep_checker_if #(
    parameter int IN_W  = 8,
    parameter int NCH   = 7,
    parameter int OUT_W = 8
);
    logic [IN_W-1:0]      a_out;
    logic [IN_W-1:0]      b_out;
    logic                 stim_valid;
    logic [NCH*OUT_W-1:0] res1;
    logic [NCH*OUT_W-1:0] res2;
    modport master (output a_out, b_out, stim_valid, input res1, res2);
    modport slave  (input a_out, b_out, stim_valid, output res1, res2);
endinterface

// File: rtl/equiv_sweep_checker_delay_line.sv
// equiv_delay_line: LAT-deep data/valid pipeline, pass-through when LAT is 0
module equiv_delay_line #(
    parameter int W   = 1,
    parameter int LAT = 0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] d,
    input  logic         dv,
    output logic [W-1:0] q,
    output logic         qv
);
    if (LAT == 0) begin : g_pass
        logic unused_clk_rst;
        assign unused_clk_rst = clock ^ reset;
        assign q  = d;
        assign qv = dv;
    end else begin : g_pipe
        logic [W-1:0]   data [LAT];
        logic [LAT-1:0] v;
        // data shift register; contents are don't-care while their valid bit is low
        always_ff @(posedge clock) begin
            data[0] <= d;
            for (int i = 1; i < LAT; i++) data[i] <= data[i-1];
        end
        // valid shift register, cleared on reset or sweep restart
        always_ff @(posedge clock) begin
            if (reset) v <= '0;
            else begin
                v[0] <= dv;
                for (int i = 1; i < LAT; i++) v[i] <= v[i-1];
            end
        end
        assign q  = data[LAT-1];
        assign qv = v[LAT-1];
    end
endmodule

// File: rtl/equiv_sweep_checker.sv
// equiv_sweep_checker: exhaustive (a,b) sweep comparing reference and candidate result channels
module equiv_sweep_checker import equiv_pkg::*; #(
    parameter  int IN_W  = 8,
    parameter  int NCH   = 7,
    parameter  int OUT_W = 8,
    parameter  int LAT   = 0,
    parameter  int CNT_W = 2*IN_W+1,
    localparam int CW    = idx_w(NCH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              stop_on_err,
    input  logic [NCH-1:0]    ch_mask,
    equiv_sweep_checker_if.master bus,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [IN_W-1:0]   err_a,
    output logic [IN_W-1:0]   err_b,
    output logic [CW-1:0]     err_ch,
    output logic [OUT_W-1:0]  err_v1,
    output logic [OUT_W-1:0]  err_v2,
    output logic [CNT_W-1:0]  mismatch_cnt
);
    localparam int DW = idx_w(LAT+1);
    state_t           state;
    logic             stop_q;
    logic [NCH-1:0]   mask_q;
    logic [DW-1:0]    dcnt;
    logic [IN_W-1:0]  da, db;
    logic             dv, go, any, hit;
    logic [CW-1:0]    ch;
    logic [OUT_W-1:0] v1, v2;
    assign go  = start && (state == IDLE || state == DONE);
    assign hit = busy && dv && any;
    equiv_delay_line #(.W(2*IN_W), .LAT(LAT)) u_dly (
        .clock (clock),
        .reset (reset | go),
        .d     ({bus.a_out, bus.b_out}),
        .dv    (bus.stim_valid),
        .q     ({da, db}),
        .qv    (dv)
    );
    // descending scan so the lowest mismatching unmasked channel wins
    always_comb begin
        any = 1'b0;
        ch  = '0;
        v1  = '0;
        v2  = '0;
        for (int i = NCH - 1; i >= 0; i--)
            if (mask_q[i] && bus.res1[i*OUT_W +: OUT_W] != bus.res2[i*OUT_W +: OUT_W]) begin
                any = 1'b1;
                ch  = CW'(i);
                v1  = bus.res1[i*OUT_W +: OUT_W];
                v2  = bus.res2[i*OUT_W +: OUT_W];
            end
    end
    // sweep FSM, operand generator and first-mismatch recorder
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            bus.a_out      <= '0;
            bus.b_out      <= '0;
            bus.stim_valid <= 1'b0;
            stop_q         <= 1'b0;
            mask_q         <= '0;
            dcnt           <= '0;
            error          <= 1'b0;
            err_a          <= '0;
            err_b          <= '0;
            err_ch         <= '0;
            err_v1         <= '0;
            err_v2         <= '0;
            mismatch_cnt   <= '0;
        end else if (go) begin
            state          <= RUN;
            busy           <= 1'b1;
            done           <= 1'b0;
            bus.a_out      <= '0;
            bus.b_out      <= '0;
            bus.stim_valid <= 1'b1;
            stop_q         <= stop_on_err;
            mask_q         <= ch_mask;
            dcnt           <= '0;
            error          <= 1'b0;
            err_a          <= '0;
            err_b          <= '0;
            err_ch         <= '0;
            err_v1         <= '0;
            err_v2         <= '0;
            mismatch_cnt   <= '0;
        end else begin
            if (hit) begin
                if (!error) begin
                    err_a  <= da;
                    err_b  <= db;
                    err_ch <= ch;
                    err_v1 <= v1;
                    err_v2 <= v2;
                end
                error <= 1'b1;
                if (!(&mismatch_cnt)) mismatch_cnt <= mismatch_cnt + 1'b1;
            end
            if (hit && stop_q) begin
                state          <= DONE;
                busy           <= 1'b0;
                done           <= 1'b1;
                bus.stim_valid <= 1'b0;
            end else if (state == RUN) begin
                if (&{bus.a_out, bus.b_out}) begin
                    state          <= (LAT > 0) ? DRAIN : DONE;
                    busy           <= (LAT > 0);
                    done           <= (LAT == 0);
                    bus.stim_valid <= 1'b0;
                end else begin
                    bus.b_out <= bus.b_out + 1'b1;
                    if (&bus.b_out) bus.a_out <= bus.a_out + 1'b1;
                end
            end else if (state == DRAIN) begin
                if (dcnt == DW'(LAT-1)) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                dcnt <= dcnt + 1'b1;
            end
        end
    end
endmodule

// File: doc/equiv_sweep_checker.md
Name: equiv_sweep_checker

Overview:
- Synthesizable exhaustive equivalence checker: drives every (a,b) operand pair of width IN_W into two externally instantiated implementations (reference and candidate).
- Compares NCH result channels cycle by cycle and records the first mismatch plus a mismatch count.
- Sits in the mvn optest harness between a stimulus-free top and the two DUT netlists; the result is readable at done.

Parameters:
- IN_W, 8, operand width of a and b.
- NCH, 7, number of compared result channels.
- OUT_W, 8, width of each channel slot; narrower channels are zero-padded by the instantiator.
- LAT, 0, DUT pipeline latency in cycles; 0 means combinational DUT, sampled in the same cycle.
- CNT_W, 2*IN_W+1, width of mismatch counter.

Ports:
- clock  in  1  single system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  pulse; begins a sweep from IDLE or DONE.
- stop_on_err  in  1  1: halt at first mismatch; 0: sweep all vectors and count. Sampled with start.
- ch_mask  in  NCH  per-channel compare enable; 0 excludes the channel. Sampled with start.
- a_out  out  IN_W  operand a to both DUTs.
- b_out  out  IN_W  operand b to both DUTs.
- stim_valid  out  1  a_out/b_out carry a live vector this cycle.
- res1  in  NCH*OUT_W  reference results; channel i at bits [i*OUT_W +: OUT_W].
- res2  in  NCH*OUT_W  candidate results, same packing.
- busy  out  1  state is RUN or DRAIN.
- done  out  1  state is DONE.
- error  out  1  at least one mismatch recorded this sweep.
- err_a, err_b  out  IN_W each  operands of the first mismatching vector.
- err_ch  out  clog2(NCH) bits, min 1  lowest-index mismatching unmasked channel of that vector.
- err_v1, err_v2  out  OUT_W each  res1/res2 of err_ch for that vector.
- mismatch_cnt  out  CNT_W  number of mismatching vectors (not channels); saturates at all-ones.

Behaviour:
- Reset:
  - State goes to IDLE.
  - All outputs go to 0, including a_out, b_out, stim_valid, error, all err_* fields and mismatch_cnt.
  - Delay-line valid bits are cleared.
  - Reset mid-sweep aborts immediately; there is no drain.
- State IDLE / DONE:
  - start=1 clears error, err_*, mismatch_cnt and delay line.
  - Latches stop_on_err and ch_mask, loads a=b=0 and moves to RUN.
  - stim_valid=1 from the next cycle.
- State RUN:
  - One vector per cycle, b is the inner index: b increments; when b wraps from 2^IN_W-1 to 0, a increments.
  - After vector (all-ones, all-ones) is presented, the next state is DRAIN (LAT>0) or DONE (LAT=0).
  - stim_valid drops with the state change.
  - start is ignored while busy.
- State DRAIN:
  - Lasts exactly LAT cycles with stim_valid=0 and a_out/b_out holding their last value.
  - Then moves to DONE.
- Delay line:
  - (a,b,valid) are delayed by LAT registers.
  - The compare stage uses the delayed copy, so vector k (presented in cycle k) is compared at the end of cycle k+LAT.
- Compare rule:
  - A vector mismatches if any channel i with ch_mask[i]=1 has unequal slices.
  - On the first mismatch, capture err_a, err_b, err_ch, err_v1 and err_v2 from the delayed operands and live res1/res2, and set error.
  - Later mismatches only increment mismatch_cnt.
- stop_on_err=1:
  - The cycle after the first mismatch is compared, the state goes to DONE directly from RUN or DRAIN.
  - In-flight vectors are discarded, not compared.
  - mismatch_cnt=1.
- Corner cases:
  - ch_mask all zero: no mismatches are possible; the sweep runs to completion with error=0.
  - Sweep length, error-free: done asserts exactly 2^(2*IN_W)+LAT+1 cycles after the start edge.

Decomposition:
- Package equiv_pkg holds:
  - the state enum {IDLE, RUN, DRAIN, DONE} (2 bits);
  - a clog2 constant function;
  - a localparam helper for the channel-index width.
- Sub-module equiv_delay_line: parametrised width and depth LAT, synchronous reset clearing only the valid bits.
  - LAT=0 generates a pass-through.
  - Reused by the checker for the (a,b,valid) bundle.

Test Plan:
- IN_W=2, NCH=3, LAT=0, identical models:
  - done after exactly 17 cycles;
  - error=0, mismatch_cnt=0;
  - stim_valid high for 16 cycles.
- IN_W=2, LAT=2, candidate wrong on channel 1 at a=2,b=1, stop_on_err=1:
  - error=1, err_a=2, err_b=1, err_ch=1;
  - err_v1/err_v2 equal the injected values;
  - done the cycle after the compare; mismatch_cnt=1.
- Same fault, stop_on_err=0, plus a second fault on channels 0 and 2 at a=3,b=3:
  - full sweep completes;
  - mismatch_cnt=2;
  - err_* still report a=2,b=1,ch=1.
- Same faults with ch_mask=3'b101:
  - a=2,b=1 ignored;
  - first capture is a=3,b=3, err_ch=0;
  - mismatch_cnt=1.
- Assert reset 5 cycles into a sweep:
  - next cycle all outputs 0, state IDLE;
  - a later start runs a full clean sweep.
- IN_W=8, NCH=7, LAT=1, equal models:
  - 65536 vectors presented, with a/b wrap observed;
  - done at cycle 65538; error=0.
